// File: rtl/hp_add_sched.sv
// hp_add_sched: shares one combinational half-precision adder between two requesters.
// A round-robin arbiter feeds a two-stage pipeline. S1 holds the operands that drive
// the shared adder. S2 holds the result. Results leave on one tagged response port
// that supports backpressure. The block also keeps a saturating count of results
// whose exception flag is non-zero.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    per-requester handshake (bit i = requester i)
//   req_a*/req_b*/req_op*  requester operands; op 0 = A+B, 1 = A-B
//   add_a/add_b/add_op     registered operands to the shared adder (S1)
//   add_sum/add_flag       combinational adder result and {UF,OF} flag
//   resp_*                 registered result (S2) with valid/ready handshake
//   busy                   S1 or S2 occupied
//   exc_cnt/clr_cnt        saturating count of flagged results; synchronous clear
module hp_add_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_a0,
  input  logic [15:0]      req_b0,
  input  logic             req_op0,
  input  logic [15:0]      req_a1,
  input  logic [15:0]      req_b1,
  input  logic             req_op1,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_op,
  input  logic [15:0]      add_sum,
  input  logic [1:0]       add_flag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [15:0]      resp_sum,
  output logic [1:0]       resp_flag,
  output logic             busy,
  output logic [CNT_W-1:0] exc_cnt,
  input  logic             clr_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic s1_v, s1_id, s2_v;
  logic last_grant;
  logic s1_rdy, s2_rdy, s1_adv;
  logic gnt_v, gnt_id, accept;

  // A full stage may still accept when its content leaves in the same cycle.
  assign s2_rdy = ~s2_v | resp_ready;
  assign s1_rdy = ~s1_v | s2_rdy;
  assign s1_adv = s1_v & s2_rdy;

  always_comb begin
    gnt_v  = |req_valid;
    gnt_id = 1'b0;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept    = gnt_v & s1_rdy;
  assign req_ready = {accept & gnt_id, accept & ~gnt_id};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v       <= 1'b0;
      s1_id      <= 1'b0;
      s2_v       <= 1'b0;
      last_grant <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      add_op     <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      resp_flag  <= '0;
      exc_cnt    <= '0;
    end else begin
      // S1 load; add_* hold their last operands while S1 is empty.
      if (accept) begin
        s1_v       <= 1'b1;
        s1_id      <= gnt_id;
        last_grant <= gnt_id;
        add_a      <= gnt_id ? req_a1  : req_a0;
        add_b      <= gnt_id ? req_b1  : req_b0;
        add_op     <= gnt_id ? req_op1 : req_op0;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end

      // S2 capture from the shared adder; otherwise drain on handshake.
      if (s1_adv) begin
        s2_v      <= 1'b1;
        resp_id   <= s1_id;
        resp_sum  <= add_sum;
        resp_flag <= add_flag;
      end else if (resp_ready) begin
        s2_v <= 1'b0;
      end

      // Clear wins over a simultaneous increment.
      if (clr_cnt) begin
        exc_cnt <= '0;
      end else if (s1_adv && (add_flag != 2'b00) && (exc_cnt != CntMax)) begin
        exc_cnt <= exc_cnt + 1'b1;
      end
    end
  end

  assign resp_valid = s2_v;
  assign busy       = s1_v | s2_v;

endmodule
